// File: rtl/quantize_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : quantize_pipe_if
// Description : Stream bundle for quantize_pipe. Carries the input beat
//               (valid/ready, packed lanes, rounding mode) and the output
//               beat (valid/ready, packed lanes, per-lane saturation flags).
//               master : upstream/downstream side (drives in_*, out_ready)
//               slave  : the requantizer (drives in_ready, out_*)
// Revision    : 1.0 - initial release
// ============================================================================
interface quantize_pipe_if #(
    parameter int ARRAY_SIZE = 4,
    parameter int IN_WIDTH   = 69,
    parameter int OUT_WIDTH  = 32
) ();
    logic                            in_valid;
    logic                            in_ready;
    logic [ARRAY_SIZE*IN_WIDTH-1:0]  in_data;
    logic [1:0]                      round_mode;
    logic                            out_valid;
    logic                            out_ready;
    logic [ARRAY_SIZE*OUT_WIDTH-1:0] out_data;
    logic [ARRAY_SIZE-1:0]           sat_flags;

    modport master (
        output in_valid, in_data, round_mode, out_ready,
        input  in_ready, out_valid, out_data, sat_flags
    );

    modport slave (
        input  in_valid, in_data, round_mode, out_ready,
        output in_ready, out_valid, out_data, sat_flags
    );
endinterface
`default_nettype wire

// File: rtl/quantize_pipe.sv
`default_nettype none
// ============================================================================
// Module      : quantize_pipe
// Description : Two-stage multi-lane fixed-point requantizer.
//               Stage 1 arithmetic-shifts each lane right by
//               IN_FRAC-OUT_FRAC and applies the beat's rounding mode
//               (0 floor, 1 half-up, 2 half-even, 3 toward-zero).
//               Stage 2 saturates to OUT_WIDTH signed and registers the
//               result with per-lane saturation flags.
// Ports       : clk           - clock, rising edge
//               rst           - asynchronous active-high reset
//               bus           - quantize_pipe_if.slave stream bundle
//               clr_sat_count - synchronous clear of sat_count
//               sat_count     - saturated lanes delivered (clamps at FFFF)
// Options     : QUANT_SAT_COUNT_EN - when defined, the saturation event
//               counter is built; otherwise sat_count reads 0 and
//               clr_sat_count is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module quantize_pipe #(
    parameter int ARRAY_SIZE = 4,
    parameter int IN_WIDTH   = 69,
    parameter int IN_FRAC    = 32,
    parameter int OUT_WIDTH  = 32,
    parameter int OUT_FRAC   = 16
) (
    input  logic              clk,
    input  logic              rst,
    quantize_pipe_if.slave    bus,
    input  logic              clr_sat_count,
    output logic [15:0]       sat_count
);

    localparam int c_shift = IN_FRAC - OUT_FRAC;
    // Rounded value keeps one extra bit above the shifted value so the
    // rounding increment can never wrap.
    localparam int c_rw    = IN_WIDTH - c_shift + 1;
    // Comparison width wide enough for both r and the output limits.
    localparam int c_cw    = ((c_rw > OUT_WIDTH) ? c_rw : OUT_WIDTH) + 1;

    localparam logic signed [c_cw-1:0] c_max =
        {{(c_cw-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [c_cw-1:0] c_min =
        {{(c_cw-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] c_max_out = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] c_min_out = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic                            r_s1_valid;
    logic                            r_s2_valid;
    logic [ARRAY_SIZE*OUT_WIDTH-1:0] r_out_data;
    logic [ARRAY_SIZE-1:0]           r_sat_flags;

    logic                            w_s1_load;
    logic                            w_s2_load;
    logic [ARRAY_SIZE*OUT_WIDTH-1:0] w_sat_data;
    logic [ARRAY_SIZE-1:0]           w_sat_flags;

    // Each stage may advance when it is empty or when its successor
    // advances, so a full pipe streams one beat per cycle.
    assign w_s2_load    = !r_s2_valid || bus.out_ready;
    assign w_s1_load    = !r_s1_valid || w_s2_load;
    assign bus.in_ready = w_s1_load;

    genvar i;
    generate
        for (i = 0; i < ARRAY_SIZE; i++) begin : g_lane
            logic signed [IN_WIDTH-1:0] w_x;
            logic signed [c_rw-1:0]     w_s;
            logic signed [c_rw-1:0]     w_r;
            logic                       w_g;
            logic                       w_st;
            logic                       w_inc;
            logic signed [c_rw-1:0]     r_s1_r;
            logic signed [c_cw-1:0]     w_rx;
            logic [OUT_WIDTH-1:0]       w_val;
            logic                       w_flag;

            assign w_x = bus.in_data[i*IN_WIDTH +: IN_WIDTH];
            // Arithmetic shift, sign-extended by one bit into the r width.
            assign w_s = {w_x[IN_WIDTH-1], w_x[IN_WIDTH-1:c_shift]};
            assign w_g = w_x[c_shift-1];

            if (c_shift > 1) begin : g_sticky
                assign w_st = |w_x[c_shift-2:0];
            end else begin : g_no_sticky
                assign w_st = 1'b0;
            end

            always_comb begin
                w_inc = 1'b0;
                case (bus.round_mode)
                    2'd0:    w_inc = 1'b0;
                    2'd1:    w_inc = w_g;
                    2'd2:    w_inc = w_g && (w_st || w_s[0]);
                    2'd3:    w_inc = w_x[IN_WIDTH-1] && (w_g || w_st);
                    default: w_inc = 1'b0;
                endcase
            end

            assign w_r = w_s + {{(c_rw-1){1'b0}}, w_inc};

            // Stage 1: rounded value; mode is consumed here so later mode
            // changes cannot touch beats already in flight.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s1_r <= '0;
                end else if (w_s1_load && bus.in_valid) begin
                    r_s1_r <= w_r;
                end
            end

            // Saturation on the stage-1 result feeding the output register.
            assign w_rx = {{(c_cw-c_rw){r_s1_r[c_rw-1]}}, r_s1_r};

            always_comb begin
                w_val  = w_rx[OUT_WIDTH-1:0];
                w_flag = 1'b0;
                if (w_rx > c_max) begin
                    w_val  = c_max_out;
                    w_flag = 1'b1;
                end else if (w_rx < c_min) begin
                    w_val  = c_min_out;
                    w_flag = 1'b1;
                end
            end

            assign w_sat_data[i*OUT_WIDTH +: OUT_WIDTH] = w_val;
            assign w_sat_flags[i]                       = w_flag;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= bus.in_valid;
        end
    end

    // Stage 2 holds its contents while stalled, keeping the output stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_out_data  <= '0;
            r_sat_flags <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data  <= w_sat_data;
                r_sat_flags <= w_sat_flags;
            end
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.out_data  = r_out_data;
    assign bus.sat_flags = r_sat_flags;

`ifdef QUANT_SAT_COUNT_EN
    localparam int c_pcw = $clog2(ARRAY_SIZE + 1);

    logic [15:0]      r_sat_count;
    logic [c_pcw-1:0] w_pop;
    logic [16:0]      w_sum;

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < ARRAY_SIZE; k++) begin
            w_pop = w_pop + c_pcw'(r_sat_flags[k]);
        end
    end

    assign w_sum = {1'b0, r_sat_count} + 17'(w_pop);

    // Clear wins over a same-cycle increment; the sum saturates at FFFF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_count <= 16'h0000;
        end else if (clr_sat_count) begin
            r_sat_count <= 16'h0000;
        end else if (r_s2_valid && bus.out_ready) begin
            r_sat_count <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
        end
    end

    assign sat_count = r_sat_count;
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_sat_count;
    assign sat_count    = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_quantize_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_quantize_pipe
// Description : Scoreboard bench for quantize_pipe. Directed beats push
//               hand-computed results into a queue; a negedge monitor pops
//               and compares on every output transfer, checks held output
//               under backpressure and tracks the expected sat_count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quantize_pipe;

    localparam int c_as = 4;
    localparam int c_iw = 69;
    localparam int c_ow = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_sat_count;
    logic [15:0] sat_count;

    always #5 clk = ~clk;

    quantize_pipe_if #(.ARRAY_SIZE(c_as), .IN_WIDTH(c_iw), .OUT_WIDTH(c_ow)) bus ();

    quantize_pipe #(
        .ARRAY_SIZE (c_as),
        .IN_WIDTH   (c_iw),
        .IN_FRAC    (32),
        .OUT_WIDTH  (c_ow),
        .OUT_FRAC   (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .clr_sat_count (clr_sat_count),
        .sat_count     (sat_count)
    );

    logic [127:0] q_data[$];
    logic [3:0]   q_flags[$];
    int           n_vec = 0;
    int           n_bad = 0;
    logic [15:0]  exp_cnt = 16'h0000;
    bit           saw_low = 0;
    int           lat;

    logic [31:0] tie_exp [4] = '{32'h0002_0000, 32'h0002_0001, 32'h0002_0000, 32'h0002_0000};
    logic [31:0] neg_exp [4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    localparam logic [68:0] c_p40k  = 69'h9C40_0000_0000;   // 40000.0

    function automatic logic [275:0] lanes(input logic [68:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [127:0] outs(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [275:0] d, input logic [1:0] m,
                        input logic [127:0] eo, input logic [3:0] ef);
        bit acc;
        acc = 0;
        bus.in_valid   = 1'b1;
        bus.in_data    = d;
        bus.round_mode = m;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) begin
                q_data.push_back(eo);
                q_flags.push_back(ef);
            end
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: in_ready never seen");
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (q_data.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(name, 128'(q_data.size()), 128'd0);
    endtask

    task automatic measure_latency(input string name);
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (bus.out_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
        @(posedge clk);
        #1;
        check(name, 128'(lat), 128'd2);
    endtask

    // Monitor / scoreboard
    logic [127:0] held_d;
    logic [3:0]   held_f;
    bit           have_held = 0;

    always @(negedge clk) begin
        logic [127:0] ed;
        logic [3:0]   ef;
        int           pc;
        int           sum;
        bit           tr;
        if (rst) begin
            have_held = 0;
        end else begin
            pc = 0;
            check("sat_count", 128'(sat_count), 128'(exp_cnt));
            if (have_held) begin
                check("held_valid", 128'(bus.out_valid), 128'd1);
                check("held_data", bus.out_data, held_d);
                check("held_flags", 128'(bus.sat_flags), 128'(held_f));
            end
            have_held = bus.out_valid && !bus.out_ready;
            held_d    = bus.out_data;
            held_f    = bus.sat_flags;
            tr        = bus.out_valid && bus.out_ready;
            if (tr) begin
                if (q_data.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got %h, expected none", bus.out_data);
                end else begin
                    ed = q_data.pop_front();
                    ef = q_flags.pop_front();
                    check("out_data", bus.out_data, ed);
                    check("sat_flags", 128'(bus.sat_flags), 128'(ef));
                    for (int k = 0; k < 4; k++) pc += int'(ef[k]);
                end
            end
`ifdef QUANT_SAT_COUNT_EN
            sum = int'(exp_cnt) + pc;
            if (clr_sat_count)  exp_cnt = 16'h0000;
            else if (tr)        exp_cnt = (sum > 65535) ? 16'hFFFF : sum[15:0];
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        clr_sat_count  = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.round_mode = 2'd0;
        bus.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_in_ready", 128'(bus.in_ready), 128'd1);
        check("rst_out_data", bus.out_data, 128'd0);
        check("rst_sat_flags", 128'(bus.sat_flags), 128'd0);
        check("rst_sat_count", 128'(sat_count), 128'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // 1.5 half-up and its latency
        send(lanes(69'h1_8000_0000, 0, 0, 0), 2'd1, outs(32'h0001_8000, 0, 0, 0), 4'h0);
        bus.in_valid = 1'b0;
        measure_latency("latency");

        // Back-to-back beats with changing modes
        send(lanes(-69'sh1_8000_0000, 0, 0, 0), 2'd1, outs(32'hFFFE_8000, 0, 0, 0), 4'h0);
        for (int m = 0; m < 4; m++)
            send(lanes(69'h2_0000_8000, 0, 0, 0), 2'(m), outs(tie_exp[m], 0, 0, 0), 4'h0);
        send(lanes(69'h2_0001_8000, 0, 0, 0), 2'd2, outs(32'h0002_0002, 0, 0, 0), 4'h0);
        for (int m = 0; m < 4; m++)
            send(lanes(-69'sh8000, 0, 0, 0), 2'(m), outs(neg_exp[m], 0, 0, 0), 4'h0);

        // Saturation
        send(lanes(c_p40k, 0, 0, 0), 2'd0, outs(32'h7FFF_FFFF, 0, 0, 0), 4'b0001);
        send(lanes(0, -69'sh9C40_0000_0000, 0, 0), 2'd1, outs(0, 32'h8000_0000, 0, 0), 4'b0010);
        send(lanes(0, 0, -69'sh8000_0000_0000, 0), 2'd2, outs(0, 0, 32'h8000_0000, 0), 4'b0000);
        send(lanes(c_p40k, c_p40k, c_p40k, c_p40k), 2'd3,
             outs(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF), 4'hF);
        bus.in_valid = 1'b0;
        drain("drain_directed");
        @(posedge clk);
        #1;
`ifdef QUANT_SAT_COUNT_EN
        check("sat_total", 128'(sat_count), 128'd6);
`else
        check("sat_total", 128'(sat_count), 128'd0);
`endif

        // Clear coinciding with a saturating transfer
        bus.out_ready = 1'b0;
        send(lanes(c_p40k, c_p40k, c_p40k, c_p40k), 2'd0,
             outs(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF), 4'hF);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        clr_sat_count = 1'b1;
        @(posedge clk);
        #1;
        clr_sat_count = 1'b0;
        check("clr_priority", 128'(sat_count), 128'd0);
        drain("drain_clr");

        // Backpressure mid-stream
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    logic [68:0] v;
                    int          e;
                    v = 69'(k + 1) << 32;
                    e = (k + 1) * 65536;
                    send(lanes(v, -v, 69'h2_0000_8000, 0), 2'(k % 4),
                         outs(32'(e), 32'(-e), tie_exp[k % 4], 0), 4'h0);
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (!bus.in_ready) saw_low = 1;
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        check("bp_in_ready_dropped", 128'(saw_low), 128'd1);
        drain("drain_bp");

        // Asynchronous reset during a saturating burst
        bus.in_data    = lanes(c_p40k, c_p40k, c_p40k, c_p40k);
        bus.round_mode = 2'd0;
        bus.in_valid   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                q_data.push_back(outs(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF));
                q_flags.push_back(4'hF);
            end
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b1;
        #1;
        check("rst_async_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_async_sat_count", 128'(sat_count), 128'd0);
        q_data.delete();
        q_flags.delete();
        exp_cnt      = 16'h0000;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        send(lanes(69'h1_8000_0000, 0, 0, 0), 2'd1, outs(32'h0001_8000, 0, 0, 0), 4'h0);
        bus.in_valid = 1'b0;
        measure_latency("latency_after_rst");
        drain("drain_final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
